wasm_linear_mem: RTL and testbench

Byte-addressable WASM linear memory. It is built on a word-wide block RAM with per-byte write enables and serves i32/i64 load/store of 1, 2, 4 or 8 bytes.
- Supports sign- or zero-extension on loads.
- Handles unaligned accesses that cross a word boundary with a two-beat sequence.
- Performs a bounds check that returns a trap instead of touching memory.
- Sits between the execute stage's load/store issue and the global data store, behind a valid/ready request/response handshake.

---
 rtl/wasm_linear_mem_pkg.sv | 58 +++++
 rtl/wasm_mem_bram.sv | 32 +++
 rtl/wasm_linear_mem.sv | 203 ++++++++++++++++++++
 tb/tb_wasm_linear_mem.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/wasm_linear_mem_pkg.sv
// Shared definitions for the WASM linear memory: size codes, FSM states, lane helpers.
package wasm_linear_mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_WR1  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // Memory size in bytes for a given number of 64-bit words.
    function automatic int unsigned calc_mem_bytes(input int unsigned depth);
        return depth * 8;
    endfunction

    // Number of bytes touched by an access of the given size code.
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'(4'd1 << sz);
    endfunction

    // Byte-enable pattern at lane 0.
    function automatic logic [7:0] size_be(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Keeps only the low bytes of store data that belong to the access.
    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 64'h0000_0000_0000_00FF;
            SZ_H:    return 64'h0000_0000_0000_FFFF;
            SZ_W:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Zero/sign extension of a lane-0 aligned load value to 64 bits.
    function automatic logic [63:0] load_extend(input logic [63:0] d, input logic [1:0] sz,
                                                input logic sgn);
        case (sz)
            SZ_B:    return {{56{sgn & d[7]}},  d[7:0]};
            SZ_H:    return {{48{sgn & d[15]}}, d[15:0]};
            SZ_W:    return {{32{sgn & d[31]}}, d[31:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/wasm_mem_bram.sv
// Word-wide block RAM: synchronous read, per-byte write enables, one port.
module wasm_mem_bram #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    i_re,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [AW-1:0]           i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Byte-masked write and registered read (old data on same-word collision).
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(DATA_WIDTH / 8); b++) begin
            if (i_be[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wasm_linear_mem.sv
// WASM linear memory: 1/2/4/8-byte loads/stores with extension, split beats and bounds trap.
module wasm_linear_mem
    import wasm_linear_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [63:0]           rsp_rdata,
    output logic                  rsp_trap
);

    localparam int unsigned WORD_AW   = $clog2(DEPTH);
    localparam int unsigned AW1       = ADDR_WIDTH + 1;
    localparam int unsigned MEM_BYTES = calc_mem_bytes(DEPTH);

    state_t               r_state;
    logic                 r_req_ready;
    logic                 r_rsp_valid;
    logic                 r_rsp_trap;
    logic [63:0]          r_rsp_rdata;
    logic [1:0]           r_size;
    logic                 r_signed;
    logic [2:0]           r_lane;
    logic [WORD_AW-1:0]   r_word;
    logic [63:0]          r_wdata;
    logic                 r_cross;
    logic [63:0]          r_lo;

    logic                 w_accept;
    logic [2:0]           w_in_lane;
    logic [WORD_AW-1:0]   w_in_word;
    logic [3:0]           w_in_nbytes;
    logic                 w_in_cross;
    logic                 w_oob;
    logic                 w_idle;
    logic [1:0]           w_st_size;
    logic [2:0]           w_st_lane;
    logic [63:0]          w_st_data;
    logic [127:0]         w_st_wide;
    logic [15:0]          w_st_be;
    logic [63:0]          w_ld_lo;
    logic [63:0]          w_ld_hi;
    logic [63:0]          w_ld_val;
    logic [63:0]          w_ld_ext;
    logic                 w_ram_re;
    logic [7:0]           w_ram_be;
    logic [WORD_AW-1:0]   w_ram_addr;
    logic [63:0]          w_ram_wdata;
    logic [63:0]          w_ram_rdata;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = req_valid && r_req_ready && w_idle;
    assign w_in_lane   = req_addr[2:0];
    assign w_in_word   = req_addr[WORD_AW+2:3];
    assign w_in_nbytes = size_bytes(req_size);
    assign w_in_cross  = (4'({1'b0, w_in_lane}) + w_in_nbytes) > 4'd8;
    assign w_oob       = (AW1'({1'b0, req_addr}) + AW1'(w_in_nbytes)) > AW1'(MEM_BYTES);

    // Store data/enables spread over a two-word window; first beat uses live inputs.
    assign w_st_size = w_idle ? req_size  : r_size;
    assign w_st_lane = w_idle ? w_in_lane : r_lane;
    assign w_st_data = w_idle ? req_wdata : r_wdata;
    assign w_st_wide = 128'(size_mask(w_st_size) & w_st_data) << {w_st_lane, 3'b000};
    assign w_st_be   = 16'(size_be(w_st_size)) << w_st_lane;

    // Load merge: low word is captured in RD0 for split loads, high word arrives in RD1.
    assign w_ld_lo  = (r_state == ST_RD1) ? r_lo : w_ram_rdata;
    assign w_ld_hi  = (r_state == ST_RD1) ? w_ram_rdata : 64'd0;
    assign w_ld_val = 64'({w_ld_hi, w_ld_lo} >> {r_lane, 3'b000});
    assign w_ld_ext = load_extend(w_ld_val, r_size, r_signed);

    // RAM port steering per state; read and write are never issued together.
    always_comb begin
        w_ram_re    = 1'b0;
        w_ram_be    = 8'd0;
        w_ram_addr  = w_in_word;
        w_ram_wdata = w_st_wide[63:0];
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_oob) begin
                    if (req_we) w_ram_be = w_st_be[7:0];
                    else        w_ram_re = 1'b1;
                end
            end
            ST_WR1: begin
                w_ram_be    = w_st_be[15:8];
                w_ram_addr  = r_word + WORD_AW'(1);
                w_ram_wdata = w_st_wide[127:64];
            end
            ST_RD0: begin
                w_ram_addr = r_word + WORD_AW'(1);
                w_ram_re   = r_cross;
            end
            default: ;
        endcase
    end

    wasm_mem_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (WORD_AW)
    ) u_bram (
        .clk     (clk),
        .i_re    (w_ram_re),
        .i_be    (w_ram_be),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Access sequencer with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_trap  <= 1'b0;
            r_rsp_rdata <= 64'd0;
            r_size      <= SZ_B;
            r_signed    <= 1'b0;
            r_lane      <= 3'd0;
            r_word      <= '0;
            r_wdata     <= 64'd0;
            r_cross     <= 1'b0;
            r_lo        <= 64'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_lane      <= w_in_lane;
                        r_word      <= w_in_word;
                        r_wdata     <= req_wdata;
                        r_cross     <= w_in_cross;
                        r_rsp_rdata <= 64'd0;
                        r_rsp_trap  <= w_oob;
                        if (w_oob) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                        end else if (req_we) begin
                            if (w_in_cross) begin
                                r_state <= ST_WR1;
                            end else begin
                                r_state     <= ST_RESP;
                                r_rsp_valid <= 1'b1;
                            end
                        end else begin
                            r_state <= ST_RD0;
                        end
                    end
                end
                ST_WR1: begin
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                end
                ST_RD0: begin
                    if (r_cross) begin
                        r_lo    <= w_ram_rdata;
                        r_state <= ST_RD1;
                    end else begin
                        r_rsp_rdata <= w_ld_ext;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RD1: begin
                    r_rsp_rdata <= w_ld_ext;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_trap  = r_rsp_trap;

endmodule

// File: tb/tb_wasm_linear_mem.sv
// Directed bench for wasm_linear_mem: latency, extension, split beats, traps, backpressure, reset.
module tb_wasm_linear_mem;

    localparam int unsigned MEM_BYTES = 1024 * 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_rdata;
    logic        rsp_trap;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wasm_linear_mem #(.DATA_WIDTH(64), .DEPTH(1024), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_trap   (rsp_trap)
    );

    // Issue one request; lat counts cycles from the accept edge to rsp_valid (99 = never accepted).
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [63:0] wd,
                          output int lat, output logic [63:0] rd, output logic tr);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (req_ready !== 1'b1) begin
            lat = 99; rd = 'x; tr = 1'bx;
        end else begin
            req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
            req_addr = a; req_wdata = wd;
            @(posedge clk); #1;
            req_valid = 1'b0;
            lat = 1;
            while (rsp_valid !== 1'b1 && lat < 20) begin
                @(posedge clk); #1; lat++;
            end
            rd = rsp_rdata; tr = rsp_trap;
            if (rsp_ready) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (rsp_rdata !== 64'd0) begin failures++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
        checks++; if (rsp_trap !== 1'b0) begin failures++; $display("FAIL reset_rsp_trap got=%b want=0", rsp_trap); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_aligned();
        int lat; logic [63:0] rd; logic tr;
        do_req(1'b1, 2'd3, 1'b0, 32'h10, 64'h0102030405060708, lat, rd, tr);
        checks++; if (lat != 1) begin failures++; $display("FAIL st_d_latency got=%0d want=1", lat); end
        checks++; if (rd !== 64'd0 || tr !== 1'b0) begin failures++; $display("FAIL st_d_ack got=%h/%b want=0/0", rd, tr); end
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 64'd0, lat, rd, tr);
        checks++; if (lat != 2) begin failures++; $display("FAIL ld_d_latency got=%0d want=2", lat); end
        checks++; if (rd !== 64'h0102030405060708) begin failures++; $display("FAIL ld_d_data got=%h want=0102030405060708", rd); end
    endtask

    task automatic test_byte_extend();
        int lat; logic [63:0] rd; logic tr;
        do_req(1'b0, 2'd0, 1'b1, 32'h17, 64'd0, lat, rd, tr);
        checks++; if (rd !== 64'h1) begin failures++; $display("FAIL ld_b_pos got=%h want=1", rd); end
        do_req(1'b1, 2'd0, 1'b0, 32'h17, 64'hFFFF_FFFF_FFFF_FF80, lat, rd, tr);
        checks++; if (lat != 1) begin failures++; $display("FAIL st_b_latency got=%0d want=1", lat); end
        do_req(1'b0, 2'd0, 1'b1, 32'h17, 64'd0, lat, rd, tr);
        checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("FAIL ld_b_signed got=%h want=ffffffffffffff80", rd); end
        do_req(1'b0, 2'd0, 1'b0, 32'h17, 64'd0, lat, rd, tr);
        checks++; if (rd !== 64'h80) begin failures++; $display("FAIL ld_b_unsigned got=%h want=80", rd); end
        do_req(1'b0, 2'd1, 1'b1, 32'h16, 64'd0, lat, rd, tr);
        checks++; if (rd !== 64'hFFFF_FFFF_FFFF_8002) begin failures++; $display("FAIL ld_h_signed got=%h want=ffffffffffff8002", rd); end
        do_req(1'b0, 2'd3, 1'b1, 32'h10, 64'd0, lat, rd, tr);
        checks++; if (rd !== 64'h8002030405060708) begin failures++; $display("FAIL ld_d_signed got=%h want=8002030405060708", rd); end
    endtask

    task automatic test_cross();
        int lat; logic [63:0] rd; logic tr;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hDD; exp_b[1] = 8'hCC; exp_b[2] = 8'hBB; exp_b[3] = 8'hAA;
        do_req(1'b1, 2'd2, 1'b0, 32'h1E, 64'h0000_0000_AABB_CCDD, lat, rd, tr);
        checks++; if (lat != 2) begin failures++; $display("FAIL st_cross_latency got=%0d want=2", lat); end
        do_req(1'b0, 2'd2, 1'b1, 32'h1E, 64'd0, lat, rd, tr);
        checks++; if (lat != 3) begin failures++; $display("FAIL ld_cross_latency got=%0d want=3", lat); end
        checks++; if (rd !== 64'hFFFF_FFFF_AABB_CCDD) begin failures++; $display("FAIL ld_cross_data got=%h want=ffffffffaabbccdd", rd); end
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 2'd0, 1'b0, 32'h1E + 32'(i), 64'd0, lat, rd, tr);
            checks++;
            if (rd !== {56'd0, exp_b[i]}) begin
                failures++; $display("FAIL cross_byte_%0d got=%h want=%h", i, rd, exp_b[i]);
            end
        end
        do_req(1'b0, 2'd1, 1'b0, 32'h20, 64'd0, lat, rd, tr);
        checks++; if (rd !== 64'hAABB) begin failures++; $display("FAIL ld_h_hiword got=%h want=aabb", rd); end
    endtask

    task automatic test_trap();
        int lat; logic [63:0] rd; logic tr;
        do_req(1'b1, 2'd3, 1'b0, MEM_BYTES - 8, 64'h1122334455667788, lat, rd, tr);
        checks++; if (tr !== 1'b0) begin failures++; $display("FAIL st_top_trap got=%b want=0", tr); end
        do_req(1'b1, 2'd3, 1'b0, MEM_BYTES - 4, 64'hFFFF_FFFF_FFFF_FFFF, lat, rd, tr);
        checks++; if (tr !== 1'b1 || lat != 1 || rd !== 64'd0) begin failures++; $display("FAIL st_oob got=trap%b lat%0d %h want=trap1 lat1 0", tr, lat, rd); end
        do_req(1'b0, 2'd3, 1'b0, MEM_BYTES - 8, 64'd0, lat, rd, tr);
        checks++; if (rd !== 64'h1122334455667788) begin failures++; $display("FAIL top_word_intact got=%h want=1122334455667788", rd); end
        do_req(1'b0, 2'd3, 1'b0, 32'h0, 64'd0, lat, rd, tr);
        checks++; if (rd[31:0] === 32'hFFFF_FFFF) begin failures++; $display("FAIL no_wrap_write got=%h want=not ffffffff", rd); end
        do_req(1'b0, 2'd2, 1'b0, MEM_BYTES - 2, 64'd0, lat, rd, tr);
        checks++; if (tr !== 1'b1 || lat != 1 || rd !== 64'd0) begin failures++; $display("FAIL ld_oob got=trap%b lat%0d %h want=trap1 lat1 0", tr, lat, rd); end
        do_req(1'b0, 2'd3, 1'b0, 32'hFFFF_FFFF, 64'd0, lat, rd, tr);
        checks++; if (tr !== 1'b1) begin failures++; $display("FAIL ld_addr_max got=%b want=1", tr); end
        do_req(1'b0, 2'd0, 1'b0, MEM_BYTES - 1, 64'd0, lat, rd, tr);
        checks++; if (tr !== 1'b0 || rd !== 64'h11) begin failures++; $display("FAIL ld_last_byte got=trap%b %h want=trap0 11", tr, rd); end
    endtask

    task automatic test_backpressure();
        int lat; logic [63:0] rd; logic tr;
        rsp_ready = 1'b0;
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 64'd0, lat, rd, tr);
        checks++; if (lat != 2) begin failures++; $display("FAIL bp_latency got=%0d want=2", lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h8002030405060708 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d got=v%b %h r%b want=v1 8002030405060708 r0", i, rsp_valid, rsp_rdata, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=v%b r%b want=v0 r1", rsp_valid, req_ready); end
        do_req(1'b0, 2'd2, 1'b0, 32'h1E, 64'd0, lat, rd, tr);
        checks++; if (lat != 3 || rd !== 64'hAABB_CCDD) begin failures++; $display("FAIL bp_next got=lat%0d %h want=lat3 aabbccdd", lat, rd); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] rd; logic tr;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h1E; req_wdata = 64'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_async got=v%b r%b want=v0 r0", rsp_valid, req_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_hold got=%b want=0", rsp_valid); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_release got=r%b v%b want=r1 v0", req_ready, rsp_valid); end
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 64'd0, lat, rd, tr);
        checks++; if (lat != 2 || rd !== 64'h8002030405060708) begin failures++; $display("FAIL rst_mid_fresh got=lat%0d %h want=lat2 8002030405060708", lat, rd); end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_byte_extend();
        test_cross();
        test_trap();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
